// File: rtl/bin_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t  : converter FSM states (IDLE, SHIFT, FINISH)
//   BCD_NINE : saturation digit shown on every position when the value overflows
//   pow10    : 10**n, used to build the overflow limit
//   clog2    : ceil(log2(v)), used to size the shift counter
package bin_bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FINISH
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'h9;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_bcd_seq_add3.sv
// Single BCD digit correction cell for the shift-add-3 algorithm.
//   digit_i : 4-bit BCD digit before the shift
//   digit_o : digit_i + 3 when digit_i > 4, otherwise digit_i unchanged
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i > 4'd4) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one input bit per clock.
// Feeds the PC display stage; bcd/overflow only change on the done strobe so the
// display never sees intermediate accumulator values.
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-low reset
//   binary   : unsigned input, sampled only when start is accepted in IDLE
//   start    : conversion request, ignored unless IDLE
//   busy     : high while shifting (IN_W cycles)
//   done     : one-cycle strobe, bcd/overflow valid and freshly updated
//   bcd      : packed BCD, [3:0] = units
//   overflow : last converted value was >= 10**DIGITS (bcd saturated to all 9s)
module bin_bcd_seq
  import bin_bcd_seq_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [IN_W-1:0]       binary,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned      BCD_W = 4 * DIGITS;
  localparam int unsigned      CNT_W = clog2(IN_W + 1);
  localparam longint unsigned  LIMIT = pow10(DIGITS);

  state_t             state_q, state_d;
  logic [IN_W-1:0]    shreg_q, shreg_d;
  logic [BCD_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               ovf_q,   ovf_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic               ovfo_q,  ovfo_d;

  logic [BCD_W-1:0]       acc_corr;
  logic [BCD_W+IN_W-1:0]  shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_corr[4*g +: 4])
    );
  end

  assign shifted = {acc_corr, shreg_q} << 1;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    ovfo_d  = ovfo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          shreg_d = binary;
          acc_d   = '0;
          cnt_d   = CNT_W'(IN_W);
          ovf_d   = (64'(binary) >= LIMIT);
        end
      end

      ST_SHIFT: begin
        acc_d   = shifted[BCD_W+IN_W-1:IN_W];
        shreg_d = shifted[IN_W-1:0];
        cnt_d   = cnt_q - CNT_W'(1);
        // Result registers load on the edge of the final shift so they are
        // already valid during the FINISH cycle that carries done.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FINISH;
          bcd_d   = ovf_q ? {DIGITS{BCD_NINE}} : shifted[BCD_W+IN_W-1:IN_W];
          ovfo_d  = ovf_q;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      ovfo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      ovfo_q  <= ovfo_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign done     = (state_q == ST_FINISH);
  assign bcd      = bcd_q;
  assign overflow = ovfo_q;

endmodule

// File: tb/tb_bin_bcd_seq.sv
module tb_bin_bcd_seq;

  localparam int unsigned IN_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] binary = '0;
  logic        start = 1'b0;
  logic        busy, done, overflow;
  logic [15:0] bcd;

  bin_bcd_seq #(.IN_W(16), .DIGITS(4)) dut (
    .clock    (clk),
    .reset    (rst_n),
    .binary   (binary),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned free_at = 0;
  bit          busy_valid = 0;
  int unsigned busy_from = 0, busy_to = 0;
  logic [15:0] shown_bcd = '0;
  logic        shown_ovf = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Decimal reference: saturate at 10000, otherwise peel digits with / and %.
  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    if (v >= 10000) return 16'h9999;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Protocol model: a start seen while free is accepted and occupies the
  // converter for IN_W+2 cycles; result due IN_W cycles after acceptance.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      busy_valid = 0;
      free_at    = 0;
      shown_bcd  = '0;
      shown_ovf  = 1'b0;
    end else if (start && cyc >= free_at) begin
      sb.push_back('{bcd: to_bcd(int'(binary)), ovf: (binary >= 16'd10000), due: cyc + IN_W});
      busy_valid = 1;
      busy_from  = cyc;
      busy_to    = cyc + IN_W - 1;
      free_at    = cyc + IN_W + 2;
    end
  end

  // Monitor: pops expectations on done and checks held outputs every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_latency", cyc, e.due);
        chk("bcd_result", 32'(bcd), 32'(e.bcd));
        chk("overflow_result", 32'(overflow), 32'(e.ovf));
        shown_bcd = e.bcd;
        shown_ovf = e.ovf;
      end
    end else if (sb.size() != 0 && cyc >= sb[0].due) begin
      chk("missing_done", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    chk("busy", 32'(busy), 32'(busy_valid && cyc >= busy_from && cyc <= busy_to));
    chk("bcd_hold", 32'(bcd), 32'(shown_bcd));
    chk("overflow_hold", 32'(overflow), 32'(shown_ovf));
  end

  task automatic convert(input logic [15:0] v);
    @(negedge clk);
    binary = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero, in-range values, exact upper bound
    convert(16'd0);     drain();
    convert(16'd1234);  drain();
    convert(16'd9999);  drain();

    // Overflow saturation, then recovery
    convert(16'd10000); drain();
    convert(16'd65535); drain();
    convert(16'd42);    drain();

    // Start re-pulsed mid-conversion with a different value is ignored
    convert(16'd500);
    repeat (5) @(negedge clk);
    convert(16'd7);
    drain();

    // Reset in the middle of a conversion
    convert(16'd4321);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_bcd", 32'(bcd), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    convert(16'd9);
    drain();

    // Start held high: back-to-back conversions; binary disturbed mid-run
    for (int v = 1; v <= 20; v++) begin
      for (int k = 0; k < IN_W + 2; k++) begin
        @(negedge clk);
        start = 1'b1;
        if (k == 0) binary = 16'(v);
        else if (k == 5) binary = 16'($urandom_range(0, 65535));
      end
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    // Random values and gaps, including starts that land while busy
    repeat (40) begin
      @(negedge clk);
      binary = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(9990, 10010))
                                           : 16'($urandom_range(0, 65535));
      start = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      start = 1'b0;
      binary = 16'($urandom_range(0, 65535));
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
